// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Load/store request and response bundle between the core's
//               load/store path (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [DATA_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Byte-addressed little-endian data RAM with fixed wait states,
//               one outstanding request and a registered response.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 2
) (
   input  wire logic            clk,
   input  wire logic            rst,
   data_mem_responder_if.slave  bus
);

   localparam logic [3:0] c_LATENCY = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [3:0]            r_count;
   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_req_ready;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;

   logic [7:0]            r_mem [0:(1<<ADDR_WIDTH)-1];

   logic                  w_err;
   logic                  w_access;
   logic                  w_store;
   logic [ADDR_WIDTH-1:0] w_a1;
   logic [ADDR_WIDTH-1:0] w_a2;
   logic [ADDR_WIDTH-1:0] w_a3;
   logic [7:0]            w_b0;
   logic [7:0]            w_b1;
   logic [7:0]            w_b2;
   logic [7:0]            w_b3;
   logic [DATA_WIDTH-1:0] w_load;

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;

   // Misaligned halves/words, reserved size codes and unsigned stores are rejected.
   always_comb begin
      w_err = 1'b0;
      case (r_funct3)
         3'b000:         w_err = 1'b0;
         3'b001:         w_err = r_addr[0];
         3'b010:         w_err = |r_addr[1:0];
         3'b100, 3'b101: w_err = r_we | (r_funct3[0] & r_addr[0]);
         default:        w_err = 1'b1;
      endcase
   end

   assign w_a1 = r_addr + ADDR_WIDTH'(1);
   assign w_a2 = r_addr + ADDR_WIDTH'(2);
   assign w_a3 = r_addr + ADDR_WIDTH'(3);
   assign w_b0 = r_mem[r_addr];
   assign w_b1 = r_mem[w_a1];
   assign w_b2 = r_mem[w_a2];
   assign w_b3 = r_mem[w_a3];

   always_comb begin
      w_load = '0;
      case (r_funct3)
         3'b000:  w_load = DATA_WIDTH'($signed(w_b0));
         3'b001:  w_load = DATA_WIDTH'($signed({w_b1, w_b0}));
         3'b010:  w_load = DATA_WIDTH'({w_b3, w_b2, w_b1, w_b0});
         3'b100:  w_load = DATA_WIDTH'(w_b0);
         3'b101:  w_load = DATA_WIDTH'({w_b1, w_b0});
         default: w_load = '0;
      endcase
   end

   // The access happens on the edge that moves WAIT into RESP.
   assign w_access = (r_state == ST_WAIT) && (r_count == 4'd0);
   assign w_store  = w_access && r_we && !w_err;

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[r_addr] <= r_wdata[7:0];
         if (r_funct3[1:0] != 2'b00) begin
            r_mem[w_a1] <= r_wdata[15:8];
         end
         if (r_funct3[1:0] == 2'b10) begin
            r_mem[w_a2] <= r_wdata[23:16];
            r_mem[w_a3] <= r_wdata[31:24];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_count     <= 4'd0;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_req_ready <= 1'b1;
               if (bus.req_valid && r_req_ready) begin
                  r_we        <= bus.req_we;
                  r_funct3    <= bus.req_funct3;
                  r_addr      <= bus.req_addr[ADDR_WIDTH-1:0];
                  r_wdata     <= bus.req_wdata;
                  r_count     <= c_LATENCY;
                  r_req_ready <= 1'b0;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_count == 4'd0) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= (w_err || r_we) ? '0 : w_load;
               end else begin
                  r_count <= r_count - 4'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
